// File: rtl/move_validator.sv
// move_validator
// Sequential Reversi move checker. One ray walker scans the eight directions
// in turn (N, NE, E, SE, S, SW, W, NW), examining one cell per cycle, and
// accumulates a per-direction capture mask, per-direction end points and the
// total number of opponent discs that the move would flip.
//
// Ports
//   clk, resetn      clock; synchronous active-low reset
//   start            request, sampled only while idle
//   x, y             candidate column / row
//   player_black     mover colour (1 = black, 0 = white)
//   board            2 bits per cell, cell (x,y) at [2*(y*N+x) +: 2];
//                    01 black, 10 white, 00/11 empty
//   busy             high while a request is being processed
//   done             one-cycle pulse; results valid from this cycle
//   legal            OR of valids
//   valids           bit d set when direction d captures
//   end_points       {ey, ex} per direction d at [d*2*COORD_W +: 2*COORD_W]
//   flip_count       total opponent discs captured
module move_validator #(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic [COORD_W-1:0]                 x,
    input  logic [COORD_W-1:0]                 y,
    input  logic                               player_black,
    input  logic [2*BOARD_DIM*BOARD_DIM-1:0]   board,
    output logic                               busy,
    output logic                               done,
    output logic                               legal,
    output logic [7:0]                         valids,
    output logic [16*COORD_W-1:0]              end_points,
    output logic [CNT_W-1:0]                   flip_count
);

    // Cursor carries two extra bits so it can step to -1 or N without wrapping.
    localparam int CW    = COORD_W + 2;
    localparam int EP_W  = 2 * COORD_W;
    localparam int IDX_W = $clog2(BOARD_DIM * BOARD_DIM) + 1;
    localparam logic [COORD_W:0]      N_U = (COORD_W+1)'(BOARD_DIM);
    localparam logic signed [CW-1:0]  N_S = CW'(BOARD_DIM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ORIGIN = 2'd1,
        S_WALK   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                           r_state;
    logic [2*BOARD_DIM*BOARD_DIM-1:0] r_board;
    logic [COORD_W-1:0]               r_x;
    logic [COORD_W-1:0]               r_y;
    logic                             r_black;
    logic [2:0]                       r_dir;
    logic signed [CW-1:0]             r_cx;
    logic signed [CW-1:0]             r_cy;
    logic [CNT_W-1:0]                 r_run;
    logic [7:0]                       r_acc_valids;
    logic [16*COORD_W-1:0]            r_acc_ends;
    logic [CNT_W-1:0]                 r_acc_cnt;

    function automatic logic signed [CW-1:0] step_dx(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: return {{(CW-1){1'b0}}, 1'b1};
            3'd5, 3'd6, 3'd7: return {CW{1'b1}};
            default:          return '0;
        endcase
    endfunction

    function automatic logic signed [CW-1:0] step_dy(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: return {CW{1'b1}};
            3'd3, 3'd4, 3'd5: return {{(CW-1){1'b0}}, 1'b1};
            default:          return '0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
        return IDX_W'(cy) * IDX_W'(BOARD_DIM) + IDX_W'(cx);
    endfunction

    function automatic logic is_empty(input logic [1:0] c);
        return (c == 2'b00) || (c == 2'b11);
    endfunction

    logic signed [CW-1:0] w_ox;
    logic signed [CW-1:0] w_oy;
    logic                 w_on;
    logic [IDX_W-1:0]     w_cur_idx;
    logic [1:0]           w_cur_cell;
    logic                 w_org_in;
    logic [IDX_W-1:0]     w_org_idx;
    logic [1:0]           w_org_cell;
    logic [1:0]           w_mine;
    logic [2:0]           w_next_dir;
    logic                 w_resolve;
    logic                 w_capture;

    assign w_ox = {2'b00, r_x};
    assign w_oy = {2'b00, r_y};

    // Index is forced to 0 off-board so the part-select never leaves the board.
    assign w_on       = !r_cx[CW-1] && (r_cx < N_S) && !r_cy[CW-1] && (r_cy < N_S);
    assign w_cur_idx  = w_on ? cell_idx(r_cx[COORD_W-1:0], r_cy[COORD_W-1:0]) : '0;
    assign w_cur_cell = r_board[{w_cur_idx, 1'b0} +: 2];

    assign w_org_in   = ({1'b0, r_x} < N_U) && ({1'b0, r_y} < N_U);
    assign w_org_idx  = w_org_in ? cell_idx(r_x, r_y) : '0;
    assign w_org_cell = r_board[{w_org_idx, 1'b0} +: 2];

    assign w_mine     = r_black ? 2'b01 : 2'b10;
    assign w_next_dir = r_dir + 3'd1;

    // Any occupied cell that is not the mover's must be the opponent's.
    assign w_resolve  = !w_on || is_empty(w_cur_cell) || (w_cur_cell == w_mine);
    assign w_capture  = w_on && (w_cur_cell == w_mine) && (r_run != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            legal      <= 1'b0;
            valids     <= '0;
            end_points <= '0;
            flip_count <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x          <= x;
                        r_y          <= y;
                        r_black      <= player_black;
                        r_board      <= board;
                        r_acc_valids <= '0;
                        r_acc_ends   <= '0;
                        r_acc_cnt    <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_ORIGIN;
                    end
                end
                S_ORIGIN: begin
                    if (!w_org_in || !is_empty(w_org_cell)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_dir   <= 3'd0;
                        r_cx    <= w_ox + step_dx(3'd0);
                        r_cy    <= w_oy + step_dy(3'd0);
                        r_run   <= '0;
                        r_state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (w_capture) begin
                        r_acc_valids[r_dir] <= 1'b1;
                        r_acc_cnt           <= r_acc_cnt + r_run;
                        for (int d = 0; d < 8; d++) begin
                            if (r_dir == 3'(d)) begin
                                r_acc_ends[d*EP_W +: EP_W] <= {r_cy[COORD_W-1:0], r_cx[COORD_W-1:0]};
                            end
                        end
                    end
                    if (w_resolve) begin
                        // Reload for the next ray in the same cycle.
                        if (r_dir == 3'd7) begin
                            r_state <= S_DONE;
                        end else begin
                            r_dir <= w_next_dir;
                            r_cx  <= w_ox + step_dx(w_next_dir);
                            r_cy  <= w_oy + step_dy(w_next_dir);
                            r_run <= '0;
                        end
                    end else begin
                        r_run <= r_run + CNT_W'(1);
                        r_cx  <= r_cx + step_dx(r_dir);
                        r_cy  <= r_cy + step_dy(r_dir);
                    end
                end
                S_DONE: begin
                    valids     <= r_acc_valids;
                    end_points <= r_acc_ends;
                    flip_count <= r_acc_cnt;
                    legal      <= |r_acc_valids;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
